// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the signals between the fetch unit, instruction memory,
// the execute-stage redirect source and the decode stage.
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;
    logic        drain_busy;

    // Fetch-unit side
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instruction, drain_busy,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );

    // Environment side: memory, execute and decode
    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instruction, drain_busy,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word fetches under a
// credit limit, buffers returned instructions with their PC in a prefetch
// FIFO and drains stale in-flight responses after a taken-branch redirect.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    instruction_fetch_unit_if.master bus
);
    localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_drain_busy;
    logic [63:0]       r_fetch_pc;
    logic [CNT_W-1:0]  r_drop_count;

    // Prefetch FIFO: instruction plus the PC it was fetched from
    logic [63:0]       r_pc_mem  [FIFO_DEPTH];
    logic [31:0]       r_ins_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    // Tag FIFO of issued addresses; its occupancy is the outstanding count
    logic [63:0]       r_tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_tag_head;
    logic [PTR_W-1:0]  r_tag_tail;
    logic [CNT_W-1:0]  r_tag_count;

    logic              w_fetch_state;
    logic [CNT_W:0]    w_credit_sum;
    logic              w_credit_ok;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_drop_base;
    logic [CNT_W-1:0]  w_drop_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [CNT_W-1:0]  w_tag_count_next;

    // Request credit, handshakes and next-count arithmetic
    always_comb begin
        w_fetch_state    = (r_state == ST_FETCH);
        w_credit_sum     = {1'b0, r_count} + {1'b0, r_tag_count};
        w_credit_ok      = (w_credit_sum < {1'b0, DEPTH_C});
        w_req_valid      = !reset && w_fetch_state && !bus.redirect_valid && w_credit_ok;
        w_req_fire       = w_req_valid && bus.imem_req_ready;
        // A response in the redirect cycle is stale, so it never enters the FIFO
        w_push           = w_fetch_state && !bus.redirect_valid && bus.imem_rsp_valid;
        w_pop            = (r_count != CNT_ZERO) && bus.if_ready;
        // Stale responses after a redirect: everything in flight plus whatever
        // an ongoing drain still expects, minus a response landing right now
        w_drop_base      = r_tag_count + (w_fetch_state ? CNT_ZERO : r_drop_count);
        w_drop_next      = w_drop_base - CNT_W'(bus.imem_rsp_valid);
        w_count_next     = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_tag_count_next = r_tag_count + CNT_W'(w_req_fire) - CNT_W'(w_push);
    end

    // FSM, fetch PC, FIFO pointers and stale-response bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_drain_busy <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_drop_count <= CNT_ZERO;
            r_head       <= PTR_ZERO;
            r_tail       <= PTR_ZERO;
            r_count      <= CNT_ZERO;
            r_tag_head   <= PTR_ZERO;
            r_tag_tail   <= PTR_ZERO;
            r_tag_count  <= CNT_ZERO;
        end else if (bus.redirect_valid) begin
            // Any decode handshake this cycle has already completed; flush the rest
            r_fetch_pc   <= bus.redirect_pc & ~64'd3;
            r_head       <= PTR_ZERO;
            r_tail       <= PTR_ZERO;
            r_count      <= CNT_ZERO;
            r_tag_head   <= PTR_ZERO;
            r_tag_tail   <= PTR_ZERO;
            r_tag_count  <= CNT_ZERO;
            r_drop_count <= w_drop_next;
            if (w_drop_next != CNT_ZERO) begin
                r_state      <= ST_DRAIN;
                r_drain_busy <= 1'b1;
            end else begin
                r_state      <= ST_FETCH;
                r_drain_busy <= 1'b0;
            end
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 64'd4;
                r_tag_tail <= r_tag_tail + PTR_ONE;
            end
            if (w_push) begin
                r_tail     <= r_tail + PTR_ONE;
                r_tag_head <= r_tag_head + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            r_count     <= w_count_next;
            r_tag_count <= w_tag_count_next;
            case (r_state)
                ST_FETCH: begin
                    r_drain_busy <= 1'b0;
                end
                ST_DRAIN: begin
                    if (bus.imem_rsp_valid) begin
                        r_drop_count <= r_drop_count - CNT_ONE;
                        if (r_drop_count == CNT_ONE) begin
                            r_state      <= ST_FETCH;
                            r_drain_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_FETCH;
                    r_drain_busy <= 1'b0;
                end
            endcase
        end
    end

    // FIFO and tag storage; cleared on reset so the presented PC/instruction read zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pc_mem[i]  <= 64'd0;
                r_ins_mem[i] <= 32'd0;
                r_tag_mem[i] <= 64'd0;
            end
        end else begin
            if (w_req_fire) begin
                r_tag_mem[r_tag_tail] <= r_fetch_pc;
            end
            if (w_push) begin
                r_pc_mem[r_tail]  <= r_tag_mem[r_tag_head];
                r_ins_mem[r_tail] <= bus.imem_rsp_data;
            end
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.if_valid       = (r_count != CNT_ZERO);
    assign bus.if_pc          = r_pc_mem[r_head];
    assign bus.if_instruction = r_ins_mem[r_head];
    assign bus.drain_busy     = r_drain_busy;

    // FIFO invariants guaranteed by the credit rule and the in-order memory
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_count == DEPTH_C)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(w_pop && (r_count == CNT_ZERO)));
    a_rsp_has_tag: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_tag_count == CNT_ZERO)));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a program-order reference model.
module tb_instruction_fetch_unit;
    localparam logic [63:0] RESET_PC = 64'd0;
    localparam int          DEPTH    = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [63:0] addr;
        int          epoch;
    } rsp_t;

    rsp_t mq[$];
    int   cyc, last_due, epoch;
    int   n_checks = 0;
    int   n_errors = 0;

    // Values sampled mid-cycle by cycle_drive
    logic        s_req_valid, s_fire, s_if_valid, s_hs, s_drain;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_ins;
    int          s_stale;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return lo + 32'h100;
    endfunction

    // Reset DUT and memory model together; returns 1 time unit after the reset edge
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.if_ready       = 1'b0;
        mq.delete();
        cyc = 0; last_due = -1; epoch = 0;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: memory model drives its response, inputs applied, outputs sampled
    task automatic cycle_drive(input bit rdy, input bit ifr, input bit redir,
                               input logic [63:0] rpc, input int lat);
        int d;
        @(negedge clk);
        reset = 1'b0;
        s_stale = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) s_stale++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.imem_req_ready = rdy;
        bus.if_ready       = ifr;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        s_req_valid = bus.imem_req_valid;
        s_addr      = bus.imem_req_addr;
        s_fire      = s_req_valid && rdy;
        s_if_valid  = bus.if_valid;
        s_hs        = s_if_valid && ifr;
        s_pc        = bus.if_pc;
        s_ins       = bus.if_instruction;
        s_drain     = bus.drain_busy;
        if (s_fire) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{due: d, addr: s_addr, epoch: epoch});
        end
        if (redir) epoch++;
        cyc++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        n_checks++; if (bus.imem_req_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_req_addr: got %h want %h", bus.imem_req_addr, RESET_PC); end
        n_checks++; if (bus.if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
        n_checks++; if (bus.if_pc !== 64'd0) begin n_errors++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
        n_checks++; if (bus.if_instruction !== 32'd0) begin n_errors++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instruction); end
        n_checks++; if (bus.drain_busy !== 1'b0) begin n_errors++; $display("FAIL reset_drain_busy: got %b want 0", bus.drain_busy); end
    endtask

    task automatic test_sequential();
        logic [63:0] e;
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 1);
            e = 64'(c) * 64'd4;
            n_checks++; if (!(s_fire && s_addr === e)) begin n_errors++; $display("FAIL seq_req c=%0d: fire=%b addr=%h want fire=1 addr=%h", c, s_fire, s_addr, e); end
            if (c < 2) begin
                n_checks++; if (s_if_valid !== 1'b0) begin n_errors++; $display("FAIL seq_early_valid c=%0d: got %b want 0", c, s_if_valid); end
            end else begin
                e = 64'(c - 2) * 64'd4;
                n_checks++; if (!(s_hs && s_pc === e && s_ins === mem_word(e))) begin n_errors++; $display("FAIL seq_deliver c=%0d: hs=%b pc=%h ins=%h want pc=%h ins=%h", c, s_hs, s_pc, s_ins, e, mem_word(e)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq, ndel;
        bit seen;
        logic [63:0] e;
        apply_reset();
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            cycle_drive(1'b1, 1'b0, 1'b0, 64'd0, 1);
            if (s_fire) begin
                n_checks++; if (s_addr !== 64'(nreq) * 64'd4) begin n_errors++; $display("FAIL bp_addr: got %h want %h", s_addr, 64'(nreq) * 64'd4); end
                nreq++;
            end
            if (c >= 4) begin
                n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_credit c=%0d: req_valid got %b want 0", c, s_req_valid); end
            end
            if (s_if_valid) begin
                n_checks++; if (s_pc !== 64'd0) begin n_errors++; $display("FAIL bp_hold_pc c=%0d: got %h want 0", c, s_pc); end
            end
        end
        n_checks++; if (nreq != 4) begin n_errors++; $display("FAIL bp_req_count: got %0d want 4", nreq); end
        e = 64'd0; ndel = 0; seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 1);
            if (s_hs) begin
                n_checks++; if (s_pc !== e) begin n_errors++; $display("FAIL bp_release_pc: got %h want %h", s_pc, e); end
                e = e + 64'd4; ndel++;
            end
            if (s_fire && !seen) begin
                seen = 1'b1;
                n_checks++; if (s_addr !== 64'h10) begin n_errors++; $display("FAIL bp_resume_addr: got %h want 10", s_addr); end
            end
        end
        n_checks++; if (ndel != 12 || !seen) begin n_errors++; $display("FAIL bp_release_count: got %0d resumed=%b want 12 resumed=1", ndel, seen); end
    endtask

    task automatic test_redirect_drain();
        int drains;
        bit got_hs, seen;
        apply_reset();
        cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 3);
        cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 3);
        cycle_drive(1'b1, 1'b1, 1'b1, 64'h200, 3);
        n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL drain_req_in_redirect: got %b want 0", s_req_valid); end
        drains = 0; got_hs = 1'b0; seen = 1'b0;
        for (int c = 3; c < 15; c++) begin
            cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 3);
            if (s_drain) drains++;
            n_checks++; if (s_drain !== (s_stale > 0)) begin n_errors++; $display("FAIL drain_busy c=%0d: got %b want %b", c, s_drain, s_stale > 0); end
            if (s_fire && !seen) begin
                seen = 1'b1;
                n_checks++; if (s_addr !== 64'h200 || c != 5) begin n_errors++; $display("FAIL drain_resume: addr=%h cycle=%0d want 200 at cycle 5", s_addr, c); end
            end
            if (s_hs && !got_hs) begin
                got_hs = 1'b1;
                n_checks++; if (s_pc !== 64'h200 || s_ins !== 32'h300) begin n_errors++; $display("FAIL drain_first_pc: pc=%h ins=%h want 200/300", s_pc, s_ins); end
            end
        end
        n_checks++; if (drains != 2) begin n_errors++; $display("FAIL drain_cycles: got %0d want 2", drains); end
        n_checks++; if (!got_hs) begin n_errors++; $display("FAIL drain_no_delivery: got none want one"); end
    endtask

    task automatic test_redirect_unaligned();
        apply_reset();
        cycle_drive(1'b1, 1'b1, 1'b1, 64'h203, 1);
        cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 1);
        n_checks++; if (!(s_fire && s_addr === 64'h200 && s_drain === 1'b0)) begin n_errors++; $display("FAIL unaligned_redirect: fire=%b addr=%h drain=%b want 1/200/0", s_fire, s_addr, s_drain); end
    endtask

    task automatic test_redirect_collision();
        logic [63:0] e;
        int drains;
        bit hs8;
        apply_reset();
        e = 64'd0; drains = 0; hs8 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cycle_drive(1'b1, 1'b1, (c == 8), 64'h400, 2);
            if (s_drain) drains++;
            if (c == 8) begin
                hs8 = s_hs;
                n_checks++; if (bus.imem_rsp_valid !== 1'b1) begin n_errors++; $display("FAIL coll_setup_rsp: got %b want 1", bus.imem_rsp_valid); end
            end
            if (s_hs) begin
                n_checks++; if (s_pc !== e) begin n_errors++; $display("FAIL coll_pc c=%0d: got %h want %h", c, s_pc, e); end
                e = e + 64'd4;
            end
            if (c == 8) e = 64'h400;
        end
        n_checks++; if (!hs8) begin n_errors++; $display("FAIL coll_handshake: got 0 want 1"); end
        n_checks++; if (drains != 1) begin n_errors++; $display("FAIL coll_drop_count: drain cycles got %0d want 1", drains); end
        n_checks++; if (e <= 64'h400) begin n_errors++; $display("FAIL coll_no_target: next pc %h want >400", e); end
    endtask

    task automatic test_wrap();
        logic [63:0] e, f;
        int nf;
        apply_reset();
        cycle_drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        e = 64'hFFFF_FFFF_FFFF_FFFC; f = e; nf = 0;
        for (int c = 0; c < 8; c++) begin
            cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 1);
            if (s_fire) begin
                n_checks++; if (s_addr !== f) begin n_errors++; $display("FAIL wrap_addr: got %h want %h", s_addr, f); end
                if (nf == 1) begin
                    n_checks++; if (s_addr !== 64'd0) begin n_errors++; $display("FAIL wrap_zero: got %h want 0", s_addr); end
                end
                f = f + 64'd4; nf++;
            end
            if (s_hs) begin
                n_checks++; if (s_pc !== e || s_ins !== mem_word(e)) begin n_errors++; $display("FAIL wrap_deliver: pc=%h ins=%h want %h/%h", s_pc, s_ins, e, mem_word(e)); end
                e = e + 64'd4;
            end
        end
    endtask

    task automatic test_reset_in_drain();
        apply_reset();
        cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 3);
        cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 3);
        cycle_drive(1'b1, 1'b1, 1'b1, 64'h200, 3);
        cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 3);
        n_checks++; if (s_drain !== 1'b1) begin n_errors++; $display("FAIL rid_in_drain: got %b want 1", s_drain); end
        apply_reset();
        n_checks++; if ({bus.imem_req_valid, bus.if_valid, bus.drain_busy} !== 3'b000) begin n_errors++; $display("FAIL rid_flags: got %b want 000", {bus.imem_req_valid, bus.if_valid, bus.drain_busy}); end
        n_checks++; if (bus.if_pc !== 64'd0 || bus.if_instruction !== 32'd0 || bus.imem_req_addr !== RESET_PC) begin n_errors++; $display("FAIL rid_values: pc=%h ins=%h addr=%h want 0/0/%h", bus.if_pc, bus.if_instruction, bus.imem_req_addr, RESET_PC); end
        cycle_drive(1'b1, 1'b1, 1'b0, 64'd0, 1);
        n_checks++; if (!(s_fire && s_addr === RESET_PC)) begin n_errors++; $display("FAIL rid_restart: fire=%b addr=%h want 1/%h", s_fire, s_addr, RESET_PC); end
    endtask

    task automatic test_random();
        logic [63:0] exp_pc, exp_fetch, rpc;
        int live;
        bit rdy, ifr, redir;
        apply_reset();
        exp_pc = RESET_PC; exp_fetch = RESET_PC; live = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            ifr   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 29) == 0);
            rpc   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, rpc[3:0]};
            cycle_drive(rdy, ifr, redir, rpc, $urandom_range(1, 3));
            n_checks++; if (s_drain !== (s_stale > 0)) begin n_errors++; $display("FAIL rnd_drain i=%0d: got %b want %b", i, s_drain, s_stale > 0); end
            if (s_fire) begin
                live++;
                n_checks++; if (s_addr !== exp_fetch || live > DEPTH) begin n_errors++; $display("FAIL rnd_req i=%0d: addr=%h live=%0d want %h live<=%0d", i, s_addr, live, exp_fetch, DEPTH); end
                exp_fetch = exp_fetch + 64'd4;
            end
            if (s_hs) begin
                n_checks++; if (s_pc !== exp_pc || s_ins !== mem_word(exp_pc)) begin n_errors++; $display("FAIL rnd_deliver i=%0d: pc=%h ins=%h want %h/%h", i, s_pc, s_ins, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                live--;
            end
            if (redir) begin
                n_checks++; if (s_req_valid !== 1'b0) begin n_errors++; $display("FAIL rnd_req_on_redirect i=%0d: got %b want 0", i, s_req_valid); end
                exp_pc = rpc & ~64'd3;
                exp_fetch = exp_pc;
                live = 0;
            end
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.if_ready       = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drain();
        test_redirect_unaligned();
        test_redirect_collision();
        test_wrap();
        test_reset_in_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
